// File: rtl/mdio_phy_responder.sv
// rtl/mdio_phy_responder.sv - Clause 22 MDIO PHY-side responder with a small PHY register file.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR      = 5'd1,
  parameter int          PREAMBLE_BITS = 32,
  parameter logic [15:0] PHY_ID1       = 16'h0007,
  parameter logic [15:0] PHY_ID2       = 16'hC0F1
) (
  input  logic        msoc_clk,
  input  logic        rstn,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        oe_mdio,
  input  logic        link_up,
  output logic        wr_strobe,
  output logic [4:0]  wr_regad,
  output logic [15:0] wr_data
);

  localparam int CW = $clog2(PREAMBLE_BITS + 1);
  localparam logic [CW-1:0] PRE_MAX = CW'(PREAMBLE_BITS);
  localparam logic [15:0] BMCR_RST = 16'h1000;
  localparam logic [15:0] ANAR_RST = 16'h01E1;

  typedef enum logic [2:0] {S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA} state_t;

  logic mdc_s1_q, mdc_s2_q, mdc_s3_q, mdio_s1_q, mdio_s2_q;
  logic rise_q, fall_q, mdio_q;
  logic rise_d, fall_d;

  state_t        state_q, state_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [4:0]    addr_q, addr_d;
  logic          is_read_q, is_read_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          oe_q, oe_d, out_q, out_d, strobe_q, strobe_d;
  logic [4:0]    wr_regad_q, wr_regad_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic [15:0]   bmcr_q, bmcr_d, anar_q, anar_d, scratch_q, scratch_d;

  logic        abort;
  logic [4:0]  shift_in;
  logic [15:0] data_in, rd_val;

  // Edges are registered so that parsing sees a one-cycle pulse paired with the MDIO sample.
  assign rise_d = mdc_s2_q & ~mdc_s3_q;
  assign fall_d = ~mdc_s2_q & mdc_s3_q;

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      mdc_s1_q  <= 1'b0;
      mdc_s2_q  <= 1'b0;
      mdc_s3_q  <= 1'b0;
      mdio_s1_q <= 1'b0;
      mdio_s2_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      mdio_q    <= 1'b0;
    end else begin
      mdc_s1_q  <= i_mdc;
      mdc_s2_q  <= mdc_s1_q;
      mdc_s3_q  <= mdc_s2_q;
      mdio_s1_q <= i_mdio;
      mdio_s2_q <= mdio_s1_q;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      mdio_q    <= mdio_s2_q;
    end
  end

  assign shift_in = {addr_q[3:0], mdio_q};
  assign data_in  = {shreg_q[14:0], mdio_q};

  always_comb begin
    rd_val = 16'h0000;
    case (shift_in)
      5'd0:    rd_val = bmcr_q & 16'h7FFF;
      5'd1:    rd_val = 16'h7809 | {13'd0, link_up, 2'b00};
      5'd2:    rd_val = PHY_ID1;
      5'd3:    rd_val = PHY_ID2;
      5'd4:    rd_val = anar_q;
      5'd31:   rd_val = scratch_q;
      default: rd_val = 16'h0000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    bit_cnt_d  = bit_cnt_q;
    addr_d     = addr_q;
    is_read_d  = is_read_q;
    shreg_d    = shreg_q;
    oe_d       = oe_q;
    out_d      = out_q;
    strobe_d   = 1'b0;
    wr_regad_d = wr_regad_q;
    wr_data_d  = wr_data_q;
    bmcr_d     = bmcr_q;
    anar_d     = anar_q;
    scratch_d  = scratch_q;
    abort      = 1'b0;
    if (rise_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (mdio_q) begin
            if (ones_q != PRE_MAX) ones_d = ones_q + CW'(1);
          end else if (ones_q == PRE_MAX) begin
            state_d = S_ST;
            ones_d  = '0;
          end else begin
            ones_d = '0;
          end
        end
        S_ST: begin
          if (mdio_q) begin
            state_d   = S_OP;
            bit_cnt_d = 5'd0;
          end else begin
            abort = 1'b1;
          end
        end
        S_OP: begin
          addr_d    = shift_in;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d = 5'd0;
            if (shift_in[1:0] == 2'b10) begin
              is_read_d = 1'b1;
              state_d   = S_PHYAD;
            end else if (shift_in[1:0] == 2'b01) begin
              is_read_d = 1'b0;
              state_d   = S_PHYAD;
            end else begin
              abort = 1'b1;
            end
          end
        end
        S_PHYAD: begin
          addr_d    = shift_in;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = 5'd0;
            if (shift_in == PHY_ADDR) state_d = S_REGAD;
            else abort = 1'b1;
          end
        end
        S_REGAD: begin
          addr_d    = shift_in;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = 5'd0;
            state_d   = S_TA;
            if (is_read_q) shreg_d = rd_val;
          end
        end
        S_TA: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d = 5'd0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (is_read_q) begin
            if (bit_cnt_q != 5'd16) bit_cnt_d = bit_cnt_q + 5'd1;
          end else begin
            shreg_d   = data_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
              strobe_d   = 1'b1;
              wr_regad_d = addr_q;
              wr_data_d  = data_in;
              state_d    = S_IDLE;
              ones_d     = '0;
              bit_cnt_d  = 5'd0;
              case (addr_q)
                5'd0: begin
                  if (data_in[15]) begin
                    bmcr_d    = BMCR_RST;
                    anar_d    = ANAR_RST;
                    scratch_d = 16'h0000;
                  end else begin
                    bmcr_d = data_in;
                  end
                end
                5'd4:    anar_d    = data_in;
                5'd31:   scratch_d = data_in;
                default: ;
              endcase
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (fall_q) begin
      case (state_q)
        S_TA: begin
          if (is_read_q && bit_cnt_q == 5'd1) begin
            oe_d  = 1'b1;
            out_d = 1'b0;
          end
        end
        S_DATA: begin
          if (is_read_q) begin
            if (bit_cnt_q == 5'd16) begin
              oe_d      = 1'b0;
              out_d     = 1'b0;
              state_d   = S_IDLE;
              ones_d    = '0;
              bit_cnt_d = 5'd0;
            end else begin
              out_d   = shreg_q[15];
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
    if (abort) begin
      state_d   = S_IDLE;
      ones_d    = '0;
      bit_cnt_d = 5'd0;
      oe_d      = 1'b0;
      out_d     = 1'b0;
    end
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      ones_q     <= '0;
      bit_cnt_q  <= 5'd0;
      addr_q     <= 5'd0;
      is_read_q  <= 1'b0;
      shreg_q    <= 16'h0000;
      oe_q       <= 1'b0;
      out_q      <= 1'b0;
      strobe_q   <= 1'b0;
      wr_regad_q <= 5'd0;
      wr_data_q  <= 16'h0000;
      bmcr_q     <= BMCR_RST;
      anar_q     <= ANAR_RST;
      scratch_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_q     <= addr_d;
      is_read_q  <= is_read_d;
      shreg_q    <= shreg_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      strobe_q   <= strobe_d;
      wr_regad_q <= wr_regad_d;
      wr_data_q  <= wr_data_d;
      bmcr_q     <= bmcr_d;
      anar_q     <= anar_d;
      scratch_q  <= scratch_d;
    end
  end

  assign o_mdio    = out_q;
  assign oe_mdio   = oe_q;
  assign wr_strobe = strobe_q;
  assign wr_regad  = wr_regad_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb/tb_mdio_phy_responder.sv - scoreboard bench for mdio_phy_responder with a register-level model.
module tb_mdio_phy_responder;

  localparam int HALF = 5;
  localparam logic [4:0] PHY = 5'd1;

  logic        clk = 1'b0;
  logic        rstn, i_mdc, mac_drv, link_up;
  logic        i_mdio, o_mdio, oe_mdio, wr_strobe;
  logic [4:0]  wr_regad;
  logic [15:0] wr_data;

  always #5 clk = ~clk;

  // Open-drain style line: the responder wins when enabled, otherwise the MAC (or pull-up).
  assign i_mdio = oe_mdio ? o_mdio : mac_drv;

  mdio_phy_responder dut (
    .msoc_clk (clk),
    .rstn     (rstn),
    .i_mdc    (i_mdc),
    .i_mdio   (i_mdio),
    .o_mdio   (o_mdio),
    .oe_mdio  (oe_mdio),
    .link_up  (link_up),
    .wr_strobe(wr_strobe),
    .wr_regad (wr_regad),
    .wr_data  (wr_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {logic [4:0] a; logic [15:0] d;} wr_t;
  logic [15:0] rd_exp_q[$];
  wr_t         wr_exp_q[$];

  logic [15:0] m_bmcr, m_anar, m_scr;

  task automatic model_reset();
    m_bmcr = 16'h1000;
    m_anar = 16'h01E1;
    m_scr  = 16'h0000;
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] a);
    case (a)
      5'd0:    return m_bmcr & 16'h7FFF;
      5'd1:    return link_up ? 16'h780D : 16'h7809;
      5'd2:    return 16'h0007;
      5'd3:    return 16'hC0F1;
      5'd4:    return m_anar;
      5'd31:   return m_scr;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0) begin
      if (d[15]) model_reset();
      else m_bmcr = d;
    end else if (a == 5'd4) m_anar = d;
    else if (a == 5'd31) m_scr = d;
  endtask

  task automatic mdc_bit(input logic b);
    mac_drv = b;
    repeat (HALF) @(posedge clk);
    #1 i_mdc = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 i_mdc = 1'b0;
  endtask

  task automatic do_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [15:0] d, input int stop_bits);
    logic bits[$];
    int   n;
    bit   valid;
    valid = (pre >= 32) && (phy == PHY) && (op == 2'b10 || op == 2'b01);
    if (valid) begin
      if (op == 2'b10) rd_exp_q.push_back(model_read(ra));
      else begin
        wr_exp_q.push_back('{a: ra, d: d});
        model_write(ra, d);
      end
    end
    bits.push_back(1'b0);
    for (int i = 0; i < pre; i++) bits.push_back(1'b1);
    bits.push_back(1'b0);
    bits.push_back(1'b1);
    bits.push_back(op[1]);
    bits.push_back(op[0]);
    for (int i = 4; i >= 0; i--) bits.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) bits.push_back(ra[i]);
    if (op == 2'b10) begin
      for (int i = 0; i < 18; i++) bits.push_back(1'b1);
    end else begin
      bits.push_back(1'b1);
      bits.push_back(1'b0);
      for (int i = 15; i >= 0; i--) bits.push_back(d[i]);
    end
    n = (stop_bits < 0) ? bits.size() : stop_bits;
    for (int i = 0; i < n; i++) mdc_bit(bits[i]);
  endtask

  logic        mdc_prev = 1'b0, oe_prev = 1'b0;
  bit          mon_active = 1'b0, mon_first = 1'b0, rel_wait = 1'b0;
  int          mon_bits = 0, rel_cnt = 0;
  logic [15:0] mon_data = 16'h0, mon_exp = 16'h0;
  wr_t         wr_cur;

  always @(negedge clk) begin
    if (!rstn) begin
      mon_active = 1'b0;
      rel_wait   = 1'b0;
    end else begin
      if (rel_wait) begin
        rel_cnt++;
        if (rel_cnt == HALF + 7) begin
          chk("oe_release", oe_mdio, 1'b0);
          rel_wait = 1'b0;
        end
      end
      if (!mon_active && !rel_wait && oe_mdio && !oe_prev) begin
        if (rd_exp_q.size() == 0) chk("unexpected_oe", oe_mdio, 1'b0);
        else begin
          chk("oe_rise_mdc_low", i_mdc, 1'b0);
          mon_exp    = rd_exp_q.pop_front();
          mon_active = 1'b1;
          mon_first  = 1'b1;
          mon_bits   = 0;
        end
      end
      if (mon_active && i_mdc && !mdc_prev) begin
        chk("oe_held", oe_mdio, 1'b1);
        if (mon_first) begin
          chk("ta_drive_zero", o_mdio, 1'b0);
          mon_first = 1'b0;
        end else begin
          mon_data = {mon_data[14:0], o_mdio};
          mon_bits++;
          if (mon_bits == 16) begin
            chk("rd_data", mon_data, mon_exp);
            mon_active = 1'b0;
            rel_wait   = 1'b1;
            rel_cnt    = 0;
          end
        end
      end
      if (wr_strobe) begin
        if (wr_exp_q.size() == 0) chk("unexpected_strobe", wr_strobe, 1'b0);
        else begin
          wr_cur = wr_exp_q.pop_front();
          chk("wr_regad", wr_regad, wr_cur.a);
          chk("wr_data", wr_data, wr_cur.d);
        end
      end
    end
    mdc_prev = i_mdc;
    oe_prev  = oe_mdio;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [4:0] regtab[8];
  int         r, opsel;
  logic [1:0] op;
  logic [4:0] phy;

  initial begin
    regtab = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd31, 5'd5, 5'd7};
    rstn = 1'b0; i_mdc = 1'b0; mac_drv = 1'b1; link_up = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_mdio", o_mdio, 1'b0);
    chk("rst_oe_mdio", oe_mdio, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_wr_regad", wr_regad, 5'd0);
    chk("rst_wr_data", wr_data, 16'h0);
    rstn = 1'b1;
    repeat (3) @(posedge clk);

    do_frame(32, 2'b10, PHY, 5'd2, 16'h0, -1);
    do_frame(33, 2'b10, PHY, 5'd3, 16'h0, -1);
    do_frame(32, 2'b01, PHY, 5'd31, 16'hA55A, -1);
    do_frame(32, 2'b10, PHY, 5'd31, 16'h0, -1);
    do_frame(32, 2'b01, PHY, 5'd4, 16'h0021, -1);
    do_frame(32, 2'b10, PHY, 5'd4, 16'h0, -1);
    do_frame(32, 2'b01, PHY, 5'd0, 16'h8000, -1);
    do_frame(32, 2'b10, PHY, 5'd4, 16'h0, -1);
    do_frame(32, 2'b10, PHY, 5'd0, 16'h0, -1);
    do_frame(32, 2'b10, PHY, 5'd31, 16'h0, -1);
    do_frame(32, 2'b01, PHY, 5'd0, 16'h1140, -1);
    do_frame(32, 2'b10, PHY, 5'd0, 16'h0, -1);
    do_frame(31, 2'b10, PHY, 5'd2, 16'h0, -1);
    do_frame(32, 2'b10, 5'd2, 5'd2, 16'h0, -1);
    do_frame(32, 2'b01, 5'd2, 5'd31, 16'hFFFF, -1);
    do_frame(32, 2'b11, PHY, 5'd2, 16'h0, -1);
    do_frame(32, 2'b00, PHY, 5'd31, 16'h1234, -1);
    do_frame(32, 2'b01, PHY, 5'd1, 16'hFFFF, -1);
    do_frame(32, 2'b10, PHY, 5'd1, 16'h0, -1);
    do_frame(32, 2'b01, PHY, 5'd7, 16'hBEEF, -1);
    do_frame(32, 2'b10, PHY, 5'd7, 16'h0, -1);
    link_up = 1'b0;
    do_frame(32, 2'b10, PHY, 5'd1, 16'h0, -1);
    link_up = 1'b1;
    do_frame(32, 2'b10, PHY, 5'd1, 16'h0, -1);

    for (int i = 0; i < 25; i++) begin
      r     = $urandom_range(0, 9);
      opsel = $urandom_range(0, 9);
      if (opsel < 5) op = 2'b10;
      else if (opsel < 9) op = 2'b01;
      else op = $urandom_range(0, 1) ? 2'b11 : 2'b00;
      phy     = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : PHY;
      link_up = 1'($urandom_range(0, 1));
      do_frame((r == 0) ? 31 : 32 + $urandom_range(0, 3), op, phy,
               regtab[$urandom_range(0, 7)], 16'($urandom), -1);
    end

    link_up = 1'b1;
    do_frame(32, 2'b10, PHY, 5'd3, 16'h0, 57);
    repeat (2) @(posedge clk);
    #1 chk("oe_before_reset", oe_mdio, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("reset_oe_async", oe_mdio, 1'b0);
    chk("reset_o_async", o_mdio, 1'b0);
    chk("reset_wr_regad", wr_regad, 5'd0);
    chk("reset_wr_data", wr_data, 16'h0);
    model_reset();
    i_mdc = 1'b0; mac_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    do_frame(32, 2'b10, PHY, 5'd0, 16'h0, -1);
    do_frame(32, 2'b10, PHY, 5'd31, 16'h0, -1);

    repeat (40) @(posedge clk);
    #1;
    chk("rd_queue_empty", rd_exp_q.size(), 0);
    chk("wr_queue_empty", wr_exp_q.size(), 0);
    chk("monitor_idle", {31'd0, mon_active}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
